// File: rtl/fetch_unit_pkg.sv
// Shared decode-interface definitions: opcode constants, instruction width, fetch FSM states.
package common_def;

  localparam int INSTR_W = 12;
  localparam int OPC_W   = 4;

  localparam logic [OPC_W-1:0] NOP    = 4'h0;
  localparam logic [OPC_W-1:0] JUMP   = 4'h1;
  localparam logic [OPC_W-1:0] BRANCH = 4'h2;
  localparam logic [OPC_W-1:0] LI     = 4'h3;
  localparam logic [OPC_W-1:0] LOAD   = 4'h4;
  localparam logic [OPC_W-1:0] STOREL = 4'h5;
  localparam logic [OPC_W-1:0] STOREU = 4'h6;
  localparam logic [OPC_W-1:0] NOT    = 4'h7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} fetch_state_t;

  // Full instruction word for an opcode with all operand bits zero.
  function automatic logic [INSTR_W-1:0] op_word(input logic [OPC_W-1:0] opc);
    return {opc, {(INSTR_W-OPC_W){1'b0}}};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Show-ahead instruction FIFO; flush empties it and takes precedence over push and pop.
module fetch_buffer #(
  parameter int             DEPTH       = 2,
  parameter int             W           = 20,
  parameter logic [W-1:0]   RESET_ENTRY = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            din,
  output logic [$clog2(DEPTH):0]  count,
  output logic [W-1:0]            head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  entry [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= RESET_ENTRY;
        end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= din;
        end
      end
      assign entry[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;
  assign head  = entry[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, buffered valid/ready output, redirect flush.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_unit
  import common_def::*;
#(
  parameter int              PC_W      = 8,
  parameter int              BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               busy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int ENT_W = INSTR_W + PC_W;

  fetch_state_t      state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [PC_W-1:0]   req_pc_reg, req_pc_next;
  logic              outstanding_reg, outstanding_next;
  logic              discard_reg, discard_next;

  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              buf_nonempty;
  logic              space;
  logic              rsp;
  logic              issue;
  logic              push;
  logic              pop;

  assign buf_nonempty = (count != '0);
  assign space        = (count + CNT_W'(outstanding_reg)) < CNT_W'(BUF_DEPTH);
  assign rsp          = outstanding_reg & imem_rvalid;
  // A response landing this cycle frees the single request slot immediately.
  assign issue        = (state_reg == S_REQ) & ~redirect_valid & fetch_en & ~halt & space
                        & (~outstanding_reg | imem_rvalid);
  assign push         = rsp & ~discard_reg & ~redirect_valid;
  assign pop          = instr_valid & instr_ready;

  fetch_buffer #(
    .DEPTH       (BUF_DEPTH),
    .W           (ENT_W),
    .RESET_ENTRY ({op_word(NOP), RESET_PC})
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({imem_rdata, req_pc_reg}),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pc_reg          <= RESET_PC;
      req_pc_reg      <= RESET_PC;
      outstanding_reg <= 1'b0;
      discard_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      req_pc_reg      <= req_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    req_pc_next      = req_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
      if (rsp) begin
        outstanding_next = 1'b0;
        discard_next     = 1'b0;
      end else if (outstanding_reg) begin
        discard_next = 1'b1;
      end
      if (state_reg != S_IDLE) begin
        if (!fetch_en)  state_next = S_IDLE;
        else if (halt)  state_next = S_HALT;
        else            state_next = S_REQ;
      end
    end else begin
      if (rsp) begin
        outstanding_next = 1'b0;
        discard_next     = 1'b0;
      end
      if (issue) begin
        outstanding_next = 1'b1;
        discard_next     = 1'b0;
        req_pc_next      = pc_reg;
        pc_next          = pc_reg + PC_W'(1);
      end
      case (state_reg)
        S_IDLE:  if (fetch_en) state_next = S_REQ;
        S_REQ: begin
          if (!fetch_en)  state_next = S_IDLE;
          else if (halt)  state_next = S_HALT;
          else if (issue) state_next = S_WAIT;
        end
        S_WAIT:  if (rsp) state_next = halt ? S_HALT : S_REQ;
        S_HALT:  if (!halt) state_next = S_REQ;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req    = issue;
    imem_addr   = pc_reg;
    instr_valid = buf_nonempty & ~redirect_valid;
    instr       = head[ENT_W-1 -: INSTR_W];
    instr_pc    = head[PC_W-1:0];
    busy        = outstanding_reg | buf_nonempty;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_reg;
  logic [15:0] perf_flushed_reg;
  logic        flush_hit;

  // Only count redirects that actually throw away a live instruction.
  assign flush_hit = redirect_valid & (buf_nonempty | (outstanding_reg & ~discard_reg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_flushed_reg <= '0;
    end else begin
      if (pop && (perf_fetched_reg != 16'hFFFF))
        perf_fetched_reg <= perf_fetched_reg + 16'd1;
      if (flush_hit && (perf_flushed_reg != 16'hFFFF))
        perf_flushed_reg <= perf_flushed_reg + 16'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer side of the instruction-decode interface.
- Holds the program counter and issues 12-bit instruction reads to instruction memory.
- Buffers returned words in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Handles jump/branch redirects from downstream: flushes buffered and in-flight instructions, then restarts fetch at the new PC.

Parameters:
- PC_W, 8, program counter / instruction address width.
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  level; allows fetch to start or continue.
- halt  input  1  level; stops new requests while high.
- imem_req  output  1  one-cycle read request pulse.
- imem_addr  output  PC_W  read address; valid while imem_req is high.
- imem_rvalid  input  1  read data valid, one cycle.
- imem_rdata  input  12  instruction word.
- instr_valid  output  1  buffer head valid to decode.
- instr  output  12  buffer head instruction.
- instr_pc  output  PC_W  address of the head instruction.
- instr_ready  input  1  decode accepts the head.
- redirect_valid  input  1  jump/branch taken.
- redirect_pc  input  PC_W  new fetch address.
- busy  output  1  request outstanding or buffer non-empty.

Behaviour:
- Reset (async, rst=1) values:
  - pc=RESET_PC, state=S_IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=NOP, instr_pc=RESET_PC.
  - buffer count=0, outstanding=0, discard=0, busy=0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HALT.
  - S_IDLE→S_REQ when fetch_en=1.
  - S_REQ: if space available (count+outstanding < BUF_DEPTH), halt=0 and fetch_en=1:
    - drive imem_req=1, imem_addr=pc;
    - pc<=pc+1, wrapping 2^PC_W−1→0;
    - outstanding<=1; →S_WAIT.
  - S_WAIT: on imem_rvalid:
    - if discard=0, push {imem_rdata, pc of that request} into the buffer;
    - clear outstanding and discard;
    - →S_REQ, or →S_HALT if halt=1.
  - S_REQ with halt=1 →S_HALT. S_HALT→S_REQ when halt=0.
  - fetch_en=0 in S_REQ →S_IDLE. An outstanding response still completes.
- Request pacing:
  - At most one outstanding request.
  - Back-to-back requests are allowed: a new imem_req may occur in the same cycle as imem_rvalid when space permits.
  - Memory latency is ≥1 cycle and arbitrary.
- Output:
  - instr_valid = (count≠0) & ~redirect_valid. The gating is combinational.
  - instr and instr_pc are the buffer head.
  - Pop on instr_valid & instr_ready.
- Full buffer: no request issues. Push and pop in the same cycle are legal and leave count unchanged.
- Redirect (redirect_valid=1):
  - Highest priority.
  - Buffer flushed to count=0; no pop occurs this cycle.
  - pc<=redirect_pc.
  - If a request is outstanding and its rvalid is not this cycle, discard<=1. An rvalid arriving this cycle is dropped.
  - No imem_req this cycle; state→S_REQ unless halt=1 or fetch_en=0.
  - Redirect in S_IDLE only loads pc.
- Simultaneous redirect and rvalid: the data is dropped and discard stays 0.
- busy = outstanding | (count≠0).

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two outputs, both cleared by reset, saturating at 16'hFFFF:
  - perf_fetched (16): increments once per accepted pop.
  - perf_flushed (16): increments once per redirect that discards at least one buffered or in-flight instruction.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package common_def supplies opcode constants (NOP, JUMP, BRANCH, LI, LOAD, STOREL, STOREU, NOT).
- Add to common_def:
  - fetch state enum type fetch_state_t;
  - INSTR_W=12.
- Sub-module fetch_buffer: synchronous FIFO, BUF_DEPTH×(12+PC_W).
  - Ports: push, pop, flush, count, head.
  - flush overrides push and pop.

Test Plan:
- Reset then fetch_en=1, memory latency 1, instr_ready=1 → imem_addr 0,1,2,3 on successive requests; instr_pc follows with 2-cycle lag; data passes through unchanged.
- instr_ready=0 for 10 cycles, latency 1 → exactly 2 requests; buffer full; imem_req stays 0; releasing ready drains in order with pc 0 then 1.
- Latency 3, redirect_valid with redirect_pc=8'h40 while request to addr 5 is outstanding → rvalid for addr 5 dropped; next imem_addr=8'h40; instr_valid=0 until data for 8'h40 arrives.
- redirect in the same cycle as imem_rvalid and instr_ready=1 with non-empty buffer → no pop; data dropped; buffer empty next cycle; discard=0.
- pc=8'hFF sequential fetch → next imem_addr=8'h00.
- halt asserted mid-WAIT → response for the outstanding request buffered; no further imem_req; halt low resumes at next pc.
- rst asserted mid-S_WAIT (async) → all outputs reach their reset values in the same cycle; a later stale rvalid with fetch_en=0 is ignored.
